// File: rtl/mult_arb_pkg.sv
// Shared definitions for the multiplier-sharing arbiter: FSM state encoding and a
// constant-safe clog2 for sizing select and counter fields.
package mult_arb_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        BUSY  = 2'd2,
        RESP  = 2'd3
    } state_e;

    // Never returns 0 so a field sized from it is always at least one bit wide.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/mult_arb_rr_pick.sv
// Combinational round-robin picker: first set request scanning upward from last+1,
// wrapping around, so the previous winner has lowest priority.
module mult_arb_rr_pick #(
    parameter int N_REQ = 4,
    parameter int SEL_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] last,
    output logic [N_REQ-1:0] pick,
    output logic [SEL_W-1:0] pick_idx,
    output logic             pick_vld
);

    logic [SEL_W-1:0] idx;

    always_comb begin
        pick     = '0;
        pick_idx = '0;
        pick_vld = 1'b0;
        idx      = '0;
        for (int off = 1; off <= N_REQ; off++) begin
            idx = SEL_W'((int'(last) + off) % N_REQ);
            if (!pick_vld && req[idx]) begin
                pick_vld  = 1'b1;
                pick[idx] = 1'b1;
                pick_idx  = idx;
            end
        end
    end

endmodule

// File: rtl/mult_share_arbiter_taint.sv
// Round-robin sequencer sharing one sequential multiplier among N_REQ requesters,
// with an optional word-level taint shadow enabled by `define MULT_ARB_TAINT_EN.
module mult_share_arbiter_taint
    import mult_arb_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int N_REQ    = 4,
    parameter int MAX_WAIT = 2*WIDTH + 6
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ-1:0]         req_t,
    input  logic [N_REQ*WIDTH-1:0]   req_a,
    input  logic [N_REQ*WIDTH-1:0]   req_a_t,
    input  logic [N_REQ*WIDTH-1:0]   req_b,
    input  logic [N_REQ*WIDTH-1:0]   req_b_t,
    output logic [N_REQ-1:0]         grant,
    output logic [N_REQ-1:0]         grant_t,
    output logic [N_REQ-1:0]         rsp_valid,
    output logic [N_REQ-1:0]         rsp_valid_t,
    output logic [2*WIDTH-1:0]       rsp_data,
    output logic [2*WIDTH-1:0]       rsp_data_t,
    output logic                     mul_start,
    output logic                     mul_start_t,
    output logic [WIDTH-1:0]         mul_a,
    output logic [WIDTH-1:0]         mul_a_t,
    output logic [WIDTH-1:0]         mul_b,
    output logic [WIDTH-1:0]         mul_b_t,
    input  logic                     mul_done,
    input  logic                     mul_done_t,
    input  logic [2*WIDTH-1:0]       mul_product,
    input  logic [2*WIDTH-1:0]       mul_product_t,
    output logic                     err
);

    localparam int SEL_W = clog2(N_REQ);
    localparam int CNT_W = clog2(MAX_WAIT + 1);

    state_e                      state, state_nxt;
    logic [SEL_W-1:0]            sel_q, last_q, pick_idx;
    logic [N_REQ-1:0]            pick;
    logic                        pick_vld;
    logic [WIDTH-1:0]            a_q, b_q;
    logic [2*WIDTH-1:0]          prod_q;
    logic [CNT_W-1:0]            cnt;
    logic                        take, timeout;
    logic [N_REQ-1:0][WIDTH-1:0] a_slot, b_slot;

    assign a_slot = req_a;
    assign b_slot = req_b;

    mult_arb_rr_pick #(.N_REQ(N_REQ), .SEL_W(SEL_W)) u_pick (
        .req      (req),
        .last     (last_q),
        .pick     (pick),
        .pick_idx (pick_idx),
        .pick_vld (pick_vld)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // grant is combinational in IDLE; rst gates it so outputs drop the moment reset asserts.
    always_comb begin
        state_nxt = state;
        take      = 1'b0;
        timeout   = 1'b0;
        grant     = '0;
        mul_start = 1'b0;
        rsp_valid = '0;
        rsp_data  = '0;
        case (state)
            IDLE: begin
                if (pick_vld && !rst) begin
                    take      = 1'b1;
                    grant     = pick;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                mul_start = 1'b1;
                state_nxt = BUSY;
            end
            BUSY: begin
                if (mul_done) begin
                    state_nxt = RESP;
                end else if (cnt == CNT_W'(MAX_WAIT - 1)) begin
                    timeout   = 1'b1;
                    state_nxt = RESP;
                end
            end
            RESP: begin
                rsp_valid[sel_q] = 1'b1;
                rsp_data         = prod_q;
                state_nxt        = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_q  <= '0;
            last_q <= SEL_W'(N_REQ - 1);
            a_q    <= '0;
            b_q    <= '0;
            prod_q <= '0;
            cnt    <= '0;
            err    <= 1'b0;
        end else begin
            if (take) begin
                sel_q <= pick_idx;
                a_q   <= a_slot[pick_idx];
                b_q   <= b_slot[pick_idx];
            end
            if (state == ISSUE)     cnt <= '0;
            else if (state == BUSY) cnt <= cnt + 1'b1;
            if (state == BUSY && mul_done) prod_q <= mul_product;
            if (timeout) begin
                prod_q <= '0;
                err    <= 1'b1;
            end
            if (state == RESP) last_q <= sel_q;
        end
    end

    assign mul_a = a_q;
    assign mul_b = b_q;

`ifdef MULT_ARB_TAINT_EN
    logic                        state_t, sel_t_q, sel_t_pick;
    logic [WIDTH-1:0]            a_t_q, b_t_q;
    logic [2*WIDTH-1:0]          prod_t_q;
    logic [N_REQ-1:0][WIDTH-1:0] a_t_slot, b_t_slot;

    assign a_t_slot   = req_a_t;
    assign b_t_slot   = req_b_t;
    assign sel_t_pick = (|req_t) | state_t;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_t  <= 1'b0;
            sel_t_q  <= 1'b0;
            a_t_q    <= '0;
            b_t_q    <= '0;
            prod_t_q <= '0;
        end else begin
            if (state == IDLE)      state_t <= |req_t;
            else if (state == BUSY) state_t <= state_t | mul_done_t;
            if (take) begin
                sel_t_q <= sel_t_pick;
                a_t_q   <= a_t_slot[pick_idx];
                b_t_q   <= b_t_slot[pick_idx];
            end
            if (state == BUSY && mul_done) prod_t_q <= mul_product_t;
            if (timeout)                   prod_t_q <= '0;
        end
    end

    assign grant_t     = (state == IDLE && !rst) ? {N_REQ{sel_t_pick}} : '0;
    assign mul_start_t = sel_t_q;
    assign mul_a_t     = a_t_q | {WIDTH{sel_t_q}};
    assign mul_b_t     = b_t_q | {WIDTH{sel_t_q}};
    assign rsp_valid_t = {N_REQ{state_t}};
    assign rsp_data_t  = prod_t_q | {(2*WIDTH){state_t}};
`else
    logic unused_taint;
    assign unused_taint = ^{req_t, req_a_t, req_b_t, mul_done_t, mul_product_t};
    assign grant_t      = '0;
    assign mul_start_t  = 1'b0;
    assign mul_a_t      = '0;
    assign mul_b_t      = '0;
    assign rsp_valid_t  = '0;
    assign rsp_data_t   = '0;
`endif

endmodule
